// File: rtl/picoblaze_prog_loader_pkg.sv
// Shared types and constants for the PicoBlaze program loader.
package prog_loader_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_INSTR_W = 18;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [3:0] WE_ALL    = 4'b1111;
  localparam logic [3:0] WE_NONE   = 4'b0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CSUM,
    S_DONE
  } state_e;

endpackage

// File: rtl/picoblaze_prog_loader_if.sv
// Byte stream, processor fetch and BRAM port-A bundle around the loader.
interface picoblaze_prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               abort;
  logic [ADDR_W-1:0]  proc_addr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [3:0]         mem_we;
  logic               proc_reset;
  logic               busy;
  logic               done;
  logic               error;

  modport master (
    output rx_data, rx_valid, abort, proc_addr,
    input  rx_ready, mem_addr, mem_wdata, mem_we, proc_reset, busy, done, error
  );

  modport slave (
    input  rx_data, rx_valid, abort, proc_addr,
    output rx_ready, mem_addr, mem_wdata, mem_we, proc_reset, busy, done, error
  );
endinterface

// File: rtl/picoblaze_prog_loader_csum.sv
// XOR accumulator over the frame body, compared against the trailing byte.
module prog_loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] cmp,
  output logic       match
);
  logic [7:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ din;
  end

  assign match = (acc == cmp);
endmodule

// File: rtl/picoblaze_prog_loader.sv
// Streams a framed program into instruction BRAM while holding the CPU in reset.
// PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to the frame.
module picoblaze_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input logic clk,
  input logic rst_n,
  picoblaze_prog_loader_if.slave bus
);
  state_e             state;
  logic               rx_ready, busy, done, error, proc_reset;
  logic [3:0]         mem_we;
  logic [INSTR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0]  load_addr, last_idx;
  logic [1:0]         len_hi, b0;
  logic [7:0]         b1;
  logic               xfer;

  assign xfer = bus.rx_valid && rx_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic csum_clr, csum_en, csum_match;

  assign csum_clr = xfer && (state == S_IDLE) && (bus.rx_data == SYNC_BYTE);
  assign csum_en  = xfer && !bus.abort &&
                    (state inside {S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2});

  prog_loader_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (csum_clr),
    .en    (csum_en),
    .din   (bus.rx_data),
    .cmp   (bus.rx_data),
    .match (csum_match)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      proc_reset <= 1'b0;
      mem_we     <= WE_NONE;
      mem_wdata  <= '0;
      load_addr  <= '0;
      last_idx   <= '0;
      len_hi     <= '0;
      b0         <= '0;
      b1         <= '0;
    end else if (bus.abort && state != S_IDLE) begin
      // Memory may be partly overwritten, so the CPU stays parked in reset.
      state      <= S_IDLE;
      rx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b1;
      proc_reset <= 1'b1;
      mem_we     <= WE_NONE;
    end else begin
      case (state)
        S_IDLE: if (xfer && bus.rx_data == SYNC_BYTE) begin
          state      <= S_LEN_HI;
          busy       <= 1'b1;
          proc_reset <= 1'b1;
          error      <= 1'b0;
          load_addr  <= '0;
        end
        S_LEN_HI: if (xfer) begin
          len_hi <= bus.rx_data[1:0];
          state  <= S_LEN_LO;
        end
        S_LEN_LO: if (xfer) begin
          last_idx <= ADDR_W'({len_hi, bus.rx_data});
          state    <= S_B0;
        end
        S_B0: if (xfer) begin
          b0    <= bus.rx_data[1:0];
          state <= S_B1;
        end
        S_B1: if (xfer) begin
          b1    <= bus.rx_data;
          state <= S_B2;
        end
        S_B2: if (xfer) begin
          mem_wdata <= INSTR_W'({b0, b1, bus.rx_data});
          mem_we    <= WE_ALL;
          rx_ready  <= 1'b0;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          mem_we <= WE_NONE;
          if (load_addr == last_idx) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            rx_ready <= 1'b1;
            state    <= S_CSUM;
`else
            done       <= 1'b1;
            busy       <= 1'b0;
            proc_reset <= 1'b0;
            state      <= S_DONE;
`endif
          end else begin
            load_addr <= load_addr + 1'b1;
            rx_ready  <= 1'b1;
            state     <= S_B0;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: if (xfer) begin
          if (csum_match) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            proc_reset <= 1'b0;
            rx_ready   <= 1'b0;
            state      <= S_DONE;
          end else begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
`endif
        S_DONE: begin
          done     <= 1'b0;
          rx_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          rx_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Fetch path is a pure mux so the CPU sees zero added latency.
  assign bus.mem_addr   = busy ? load_addr : bus.proc_addr;
  assign bus.rx_ready   = rx_ready;
  assign bus.mem_we     = mem_we;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.proc_reset = proc_reset;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;
endmodule
